// File: rtl/range_stats_pkg.sv
// Shared definitions for the range statistics unit: FSM state encoding.
// The result record depends on WIDTH/CNT_W, so it is declared inside the top.
package range_stats_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACTIVE = 2'd1;
  localparam state_t DONE   = 2'd2;

endpackage

// File: rtl/range_minmax_update.sv
// Combinational min/max update of the working statistics against one sample.
// An unseeded state takes the sample as both min and max.
module range_minmax_update
  import range_stats_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] min_in,
  input  logic [WIDTH-1:0] max_in,
  input  logic             seeded_in,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] min_next,
  output logic [WIDTH-1:0] max_next,
  output logic             seeded_next
);

  logic less_s;
  logic greater_s;

  // Sample versus current extremes, signed or unsigned as configured.
  always_comb begin
    if (SIGNED != 0) begin
      less_s    = $signed(sample) < $signed(min_in);
      greater_s = $signed(sample) > $signed(max_in);
    end else begin
      less_s    = sample < min_in;
      greater_s = sample > max_in;
    end
  end

  // Seed on the first sample, otherwise widen the min/max window.
  always_comb begin
    min_next    = min_in;
    max_next    = max_in;
    seeded_next = seeded_in;
    if (sample_valid) begin
      if (!seeded_in) begin
        min_next    = sample;
        max_next    = sample;
        seeded_next = 1'b1;
      end else begin
        if (less_s) begin
          min_next = sample;
        end else begin
          min_next = min_in;
        end
        if (greater_s) begin
          max_next = sample;
        end else begin
          max_next = max_in;
        end
      end
    end else begin
      seeded_next = seeded_in;
    end
  end

endmodule

// File: rtl/range_stats_unit.sv
// Framed-burst statistics: min, max, range and count between go and finish,
// presented through a registered valid/ready result with sticky error.
module range_stats_unit
  import range_stats_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  input  logic             go,
  input  logic             finish,
  input  logic             result_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] range_out,
  output logic [CNT_W-1:0] count_out,
  output logic             empty,
  output logic             cnt_sat,
  output logic             error
);

  typedef struct packed {
    logic [WIDTH-1:0] min;
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] range;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             cnt_sat;
  } result_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r;
  logic [WIDTH-1:0] min_r;
  logic [WIDTH-1:0] max_r;
  logic             seeded_r;
  logic [CNT_W-1:0] count_r;
  logic             sat_r;
  logic             error_r;
  logic             result_valid_r;
  result_t          result_r;

  logic             start_s;
  logic             close_s;
  logic             active_s;
  logic [WIDTH-1:0] base_min_s;
  logic [WIDTH-1:0] base_max_s;
  logic             base_seeded_s;
  logic [CNT_W-1:0] base_count_s;
  logic             base_sat_s;
  logic [WIDTH-1:0] min_next_s;
  logic [WIDTH-1:0] max_next_s;
  logic             seeded_next_s;
  logic [CNT_W-1:0] count_next_s;
  logic             sat_next_s;
  logic             error_next_s;
  result_t          result_next_s;

  assign active_s = (state_r == ACTIVE);
  assign start_s  = go && !finish &&
                    ((state_r == IDLE) || ((state_r == DONE) && result_ready));
  assign close_s  = active_s && finish;

  // A new session starts from cleared stats; an open one accumulates.
  always_comb begin
    if (active_s) begin
      base_min_s    = min_r;
      base_max_s    = max_r;
      base_seeded_s = seeded_r;
      base_count_s  = count_r;
      base_sat_s    = sat_r;
    end else begin
      base_min_s    = {WIDTH{1'b0}};
      base_max_s    = {WIDTH{1'b0}};
      base_seeded_s = 1'b0;
      base_count_s  = {CNT_W{1'b0}};
      base_sat_s    = 1'b0;
    end
  end

  range_minmax_update #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_minmax (
    .min_in       (base_min_s),
    .max_in       (base_max_s),
    .seeded_in    (base_seeded_s),
    .sample       (data_in),
    .sample_valid (data_valid),
    .min_next     (min_next_s),
    .max_next     (max_next_s),
    .seeded_next  (seeded_next_s)
  );

  // Saturating sample counter; a blocked increment flags saturation.
  always_comb begin
    count_next_s = base_count_s;
    sat_next_s   = base_sat_s;
    if (data_valid) begin
      if (base_count_s == CNT_MAX) begin
        sat_next_s = 1'b1;
      end else begin
        count_next_s = base_count_s + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      count_next_s = base_count_s;
    end
  end

  // Result record; an empty session reports zeros with the empty flag.
  always_comb begin
    result_next_s = '0;
    if (count_next_s == {CNT_W{1'b0}}) begin
      result_next_s.empty   = 1'b1;
      result_next_s.cnt_sat = sat_next_s;
    end else begin
      result_next_s.min     = min_next_s;
      result_next_s.max     = max_next_s;
      result_next_s.range   = max_next_s - min_next_s;
      result_next_s.count   = count_next_s;
      result_next_s.cnt_sat = sat_next_s;
    end
  end

  // Sticky protocol error, cleared only by an accepted go.
  always_comb begin
    error_next_s = error_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          error_next_s = 1'b0;
        end else if (finish) begin
          error_next_s = 1'b1;
        end else begin
          error_next_s = error_r;
        end
      end
      ACTIVE: begin
        if (go) begin
          error_next_s = 1'b1;
        end else begin
          error_next_s = error_r;
        end
      end
      DONE: begin
        if (start_s) begin
          error_next_s = 1'b0;
        end else if (finish || (go && !result_ready)) begin
          error_next_s = 1'b1;
        end else begin
          error_next_s = error_r;
        end
      end
      default: error_next_s = error_r;
    endcase
  end

  // FSM, working stats and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      min_r          <= {WIDTH{1'b0}};
      max_r          <= {WIDTH{1'b0}};
      seeded_r       <= 1'b0;
      count_r        <= {CNT_W{1'b0}};
      sat_r          <= 1'b0;
      error_r        <= 1'b0;
      result_valid_r <= 1'b0;
      result_r       <= '0;
    end else begin
      error_r <= error_next_s;
      case (state_r)
        IDLE:    state_r <= start_s ? ACTIVE : IDLE;
        ACTIVE:  state_r <= finish ? DONE : ACTIVE;
        DONE:    state_r <= result_ready ? (start_s ? ACTIVE : IDLE) : DONE;
        default: state_r <= IDLE;
      endcase
      if (start_s || active_s) begin
        min_r    <= min_next_s;
        max_r    <= max_next_s;
        seeded_r <= seeded_next_s;
        count_r  <= count_next_s;
        sat_r    <= sat_next_s;
      end
      if (close_s) begin
        result_r       <= result_next_s;
        result_valid_r <= 1'b1;
      end else if ((state_r == DONE) && result_ready) begin
        result_valid_r <= 1'b0;
      end
    end
  end

  assign busy         = active_s;
  assign result_valid = result_valid_r;
  assign min_out      = result_r.min;
  assign max_out      = result_r.max;
  assign range_out    = result_r.range;
  assign count_out    = result_r.count;
  assign empty        = result_r.empty;
  assign cnt_sat      = result_r.cnt_sat;
  assign error        = error_r;

endmodule

// File: tb/tb_range_stats_unit.sv
// Directed bench: three instances (unsigned/16, signed/8, unsigned/16 with a
// 3-bit counter) share one stimulus bus; each scenario checks the relevant one.
module tb_range_stats_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = 16'd0;
  logic        data_valid = 1'b0;
  logic        go = 1'b0;
  logic        finish = 1'b0;
  logic        result_ready = 1'b0;

  logic        u_busy, u_rv, u_empty, u_sat, u_err;
  logic [15:0] u_min, u_max, u_range;
  logic [7:0]  u_cnt;
  logic        s_busy, s_rv, s_empty, s_sat, s_err;
  logic [7:0]  s_min, s_max, s_range;
  logic [7:0]  s_cnt;
  logic        c_busy, c_rv, c_empty, c_sat, c_err;
  logic [15:0] c_min, c_max, c_range;
  logic [2:0]  c_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  range_stats_unit #(.WIDTH(16), .CNT_W(8), .SIGNED(0)) dut_u (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .go(go), .finish(finish), .result_ready(result_ready),
    .busy(u_busy), .result_valid(u_rv), .min_out(u_min), .max_out(u_max),
    .range_out(u_range), .count_out(u_cnt), .empty(u_empty), .cnt_sat(u_sat),
    .error(u_err));

  range_stats_unit #(.WIDTH(8), .CNT_W(8), .SIGNED(1)) dut_s (
    .clock(clock), .reset(reset), .data_in(data_in[7:0]), .data_valid(data_valid),
    .go(go), .finish(finish), .result_ready(result_ready),
    .busy(s_busy), .result_valid(s_rv), .min_out(s_min), .max_out(s_max),
    .range_out(s_range), .count_out(s_cnt), .empty(s_empty), .cnt_sat(s_sat),
    .error(s_err));

  range_stats_unit #(.WIDTH(16), .CNT_W(3), .SIGNED(0)) dut_c (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .go(go), .finish(finish), .result_ready(result_ready),
    .busy(c_busy), .result_valid(c_rv), .min_out(c_min), .max_out(c_max),
    .range_out(c_range), .count_out(c_cnt), .empty(c_empty), .cnt_sat(c_sat),
    .error(c_err));

  typedef struct {
    logic        go, fin, dv, rr;
    logic [15:0] data;
    logic        busy, rv, err;
    logic [15:0] mn, mx, rg;
    logic [7:0]  cnt;
    logic        emp, sat;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic g, input logic f, input logic dv,
                              input logic rr, input logic [15:0] d,
                              input logic b, input logic rv, input logic e,
                              input logic [15:0] mn, input logic [15:0] mx,
                              input logic [15:0] rg, input logic [7:0] cnt,
                              input logic emp, input logic sat);
    vec_t v;
    v.go = g; v.fin = f; v.dv = dv; v.rr = rr; v.data = d;
    v.busy = b; v.rv = rv; v.err = e;
    v.mn = mn; v.mx = mx; v.rg = rg; v.cnt = cnt; v.emp = emp; v.sat = sat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic g, input logic f, input logic dv,
                      input logic rr, input logic [15:0] d);
    go = g; finish = f; data_valid = dv; result_ready = rr; data_in = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Unsigned session, protocol errors, empty session (checked on dut_u).
    vecs[0]  = mk(1'b1,1'b0,1'b1,1'b0,16'd5,  1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'd0,1'b0,1'b0);
    vecs[1]  = mk(1'b0,1'b0,1'b1,1'b0,16'd9,  1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'd0,1'b0,1'b0);
    vecs[2]  = mk(1'b0,1'b0,1'b1,1'b0,16'd2,  1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'd0,1'b0,1'b0);
    vecs[3]  = mk(1'b0,1'b0,1'b1,1'b0,16'd7,  1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'd0,1'b0,1'b0);
    vecs[4]  = mk(1'b0,1'b1,1'b1,1'b0,16'd4,  1'b0,1'b1,1'b0, 16'd2,16'd9,16'd7,8'd5,1'b0,1'b0);
    vecs[5]  = mk(1'b0,1'b0,1'b1,1'b0,16'd1,  1'b0,1'b1,1'b0, 16'd2,16'd9,16'd7,8'd5,1'b0,1'b0);
    vecs[6]  = mk(1'b0,1'b0,1'b0,1'b1,16'd0,  1'b0,1'b0,1'b0, 16'd0,16'd0,16'd0,8'd0,1'b0,1'b0);
    vecs[7]  = mk(1'b0,1'b1,1'b0,1'b0,16'd0,  1'b0,1'b0,1'b1, 16'd0,16'd0,16'd0,8'd0,1'b0,1'b0);
    vecs[8]  = mk(1'b1,1'b0,1'b0,1'b0,16'd0,  1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'd0,1'b0,1'b0);
    vecs[9]  = mk(1'b0,1'b0,1'b1,1'b0,16'd10, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'd0,1'b0,1'b0);
    vecs[10] = mk(1'b1,1'b0,1'b0,1'b0,16'd0,  1'b1,1'b0,1'b1, 16'd0,16'd0,16'd0,8'd0,1'b0,1'b0);
    vecs[11] = mk(1'b0,1'b1,1'b1,1'b0,16'd3,  1'b0,1'b1,1'b1, 16'd3,16'd10,16'd7,8'd2,1'b0,1'b0);
    vecs[12] = mk(1'b0,1'b0,1'b0,1'b1,16'd0,  1'b0,1'b0,1'b1, 16'd0,16'd0,16'd0,8'd0,1'b0,1'b0);
    vecs[13] = mk(1'b1,1'b0,1'b0,1'b0,16'd0,  1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'd0,1'b0,1'b0);
    vecs[14] = mk(1'b0,1'b0,1'b0,1'b0,16'd0,  1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'd0,1'b0,1'b0);
    vecs[15] = mk(1'b0,1'b1,1'b0,1'b0,16'd0,  1'b0,1'b1,1'b0, 16'd0,16'd0,16'd0,8'd0,1'b1,1'b0);
    vecs[16] = mk(1'b0,1'b0,1'b0,1'b1,16'd0,  1'b0,1'b0,1'b0, 16'd0,16'd0,16'd0,8'd0,1'b0,1'b0);

    // Reset state.
    @(posedge clock); #1;
    chk("reset busy", 32'(u_busy), 32'd0);
    chk("reset rv", 32'(u_rv), 32'd0);
    chk("reset min", 32'(u_min), 32'd0);
    chk("reset cnt", 32'(u_cnt), 32'd0);
    chk("reset err", 32'(u_err), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].go, vecs[i].fin, vecs[i].dv, vecs[i].rr, vecs[i].data);
      chk($sformatf("vec%0d busy", i), 32'(u_busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d rv", i), 32'(u_rv), 32'(vecs[i].rv));
      chk($sformatf("vec%0d err", i), 32'(u_err), 32'(vecs[i].err));
      if (vecs[i].rv) begin
        chk($sformatf("vec%0d min", i), 32'(u_min), 32'(vecs[i].mn));
        chk($sformatf("vec%0d max", i), 32'(u_max), 32'(vecs[i].mx));
        chk($sformatf("vec%0d range", i), 32'(u_range), 32'(vecs[i].rg));
        chk($sformatf("vec%0d cnt", i), 32'(u_cnt), 32'(vecs[i].cnt));
        chk($sformatf("vec%0d empty", i), 32'(u_empty), 32'(vecs[i].emp));
        chk($sformatf("vec%0d sat", i), 32'(u_sat), 32'(vecs[i].sat));
      end
    end

    // Signed extremes on the 8-bit signed instance.
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0080);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h007F);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    chk("signed rv", 32'(s_rv), 32'd1);
    chk("signed min", 32'(s_min), 32'h80);
    chk("signed max", 32'(s_max), 32'h7F);
    chk("signed range", 32'(s_range), 32'hFF);
    chk("signed cnt", 32'(s_cnt), 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    chk("signed drop", 32'(s_rv), 32'd0);

    // Saturation on the 3-bit counter instance: samples 1..10.
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
    for (int k = 2; k <= 9; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 16'(k));
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'd10);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("sat hold%0d rv", k), 32'(c_rv), 32'd1);
      chk($sformatf("sat hold%0d cnt", k), 32'(c_cnt), 32'd7);
      chk($sformatf("sat hold%0d flag", k), 32'(c_sat), 32'd1);
      chk($sformatf("sat hold%0d range", k), 32'({c_min, c_max, c_range}),
          32'({16'd1, 16'd10, 16'd9}));
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'd99);
    end
    // Back-to-back: result_ready with go.
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'd20);
    chk("b2b busy", 32'(c_busy), 32'd1);
    chk("b2b rv", 32'(c_rv), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'd30);
    chk("b2b cnt", 32'(c_cnt), 32'd2);
    chk("b2b sat", 32'(c_sat), 32'd0);
    chk("b2b min", 32'(c_min), 32'd20);
    chk("b2b max", 32'(c_max), 32'd30);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);

    // Asynchronous reset in the middle of a session.
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'd40);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'd41);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'd42);
    go = 1'b0; data_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst busy", 32'(u_busy), 32'd0);
    chk("arst min", 32'(u_min), 32'd0);
    chk("arst max", 32'(u_max), 32'd0);
    chk("arst cnt", 32'(c_cnt), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      chk($sformatf("post-reset%0d rv", k), 32'(u_rv), 32'd0);
      chk($sformatf("post-reset%0d busy", k), 32'(u_busy), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/range_stats_unit.md
Name: range_stats_unit

Overview:
Parametrised successor to the team's single-channel range finder. It measures a framed burst of samples, where a session is opened by go and closed by finish, and reports min, max, range and sample count through a registered result with a valid/ready handshake. It adds per-sample qualification, signed mode, an empty-session flag, count saturation and sticky protocol-error reporting. It sits between the io_in sample bus and the io_out readout mux in my_chip.

Parameters:
WIDTH, 16, sample width in bits (>=2)
CNT_W, 8, sample-counter width in bits
SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  WIDTH  sample
data_valid  input  1  data_in is a sample this cycle
go  input  1  open a session
finish  input  1  close the session
result_ready  input  1  consumer accepts the result
busy  output  1  session open (state ACTIVE)
result_valid  output  1  result registers hold a completed session
min_out  output  WIDTH  session minimum
max_out  output  WIDTH  session maximum
range_out  output  WIDTH  max_out - min_out, unsigned
count_out  output  CNT_W  accepted samples, saturating
empty  output  1  session closed with zero samples
cnt_sat  output  1  count saturated during the session
error  output  1  sticky protocol error

Behaviour:
- Reset is asynchronous and active-high; the clock is clock. On reset: state IDLE, and every output and internal register is 0. Reset mid-session discards the session and produces no result.
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - go=1 and finish=0 -> ACTIVE next cycle. Working stats are cleared and error is cleared.
  - If data_valid is 1 on the go cycle, that sample seeds min and max, and count=1.
  - finish=1 while not starting (including go&finish together) -> error<=1, stay in IDLE.
- ACTIVE:
  - Each cycle with data_valid=1 is one accepted sample.
  - First sample seeds min and max. Later samples: min<=data_in if data_in<min; max<=data_in if data_in>max. Comparisons are signed when SIGNED=1.
  - count increments by 1 per sample, saturating at 2^CNT_W-1. An attempted increment at saturation sets cnt_sat.
  - finish=1: a valid sample on the finish cycle is included. Move to DONE. Result registers load from the updated stats on that edge, so result_valid=1 the cycle after finish (latency 1).
  - go=1 with finish=0 -> error<=1, go ignored, session continues.
  - go=1 with finish=1 -> handled as finish, and error<=1.
- DONE:
  - Result outputs hold stable while result_valid=1.
  - Leave only on result_ready=1:
    - with go=0 -> IDLE;
    - with go=1 and finish=0 -> directly to ACTIVE (back-to-back session, go-cycle sample rules as in IDLE).
  - go without result_ready -> error<=1, ignored.
  - finish -> error<=1.
  - data_valid is ignored.
- Empty session (count=0 at finish): min_out=max_out=range_out=0, empty=1.
- range_out is WIDTH bits unsigned. Signed worst case (max=2^(WIDTH-1)-1, min=-2^(WIDTH-1)) gives 2^WIDTH-1 and must not wrap.
- result_valid drops the cycle after result_ready is seen. Result data registers keep their values until the next load.
- busy=1 exactly in ACTIVE.
- error stays set until the next accepted go.

Decomposition:
- Package range_stats_pkg holds: state enum (IDLE, ACTIVE, DONE) and a result struct (min, max, range, count, empty, cnt_sat), parametrised by WIDTH/CNT_W.
- One sub-module, range_minmax_update: combinational compare/update of {min, max, seeded} against a sample, honouring SIGNED.
- Top: FSM, counter, result registers.

Test Plan:
1. Unsigned, WIDTH=16: go+sample 5, then samples 9, 2, 7, then finish with sample 4 -> next cycle result_valid=1, min=2, max=9, range=7, count=5; result_ready -> IDLE.
2. SIGNED=1, WIDTH=8: samples 0x80, 0x7F, 0x00 -> min=0x80, max=0x7F, range=0xFF, count=3.
3. Protocol errors:
   - finish in IDLE -> error=1, no result.
   - Then go -> error clears.
   - go inside ACTIVE -> error=1 and stats unchanged.
4. Empty session: go and finish with data_valid=0 throughout -> empty=1, count=0, min=max=range=0.
5. Saturation and back-to-back:
   - CNT_W=3: 10 samples -> count=7, cnt_sat=1.
   - Hold result_ready=0 for 5 cycles -> outputs stable.
   - Then result_ready+go together -> busy=1 next cycle with fresh stats.
6. Reset asserted mid-ACTIVE after 3 samples -> all outputs 0 immediately (asynchronous), state IDLE, no result_valid after release.
